router_sync_n: RTL and testbench
================================

Name: router_sync_n

Overview:
Parametrised N-channel synchronizer between the router FSM/register front end and the per-destination output FIFOs. It latches the packet destination address and steers the write enable to one FIFO. It muxes the selected FIFO's full flag back to the FSM, drives per-channel valid_out, and issues single-cycle soft resets to any FIFO whose head is not read within a programmable timeout. It generalises the fixed 3-channel synchronizer: channel count, address width and timeout are parameters, and it adds invalid-address detection and an explicit per-channel timeout FSM.

Parameters:
NUM_CH, 3, number of destination FIFOs (2..16)
ADDR_W, 2, width of data_in address field; 2**ADDR_W >= NUM_CH required
TIMEOUT, 30, consecutive unread-valid cycles before soft reset (2..1024)
CNT_W, $clog2(TIMEOUT), timeout counter width (localparam)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous reset, active-high
detect_add  in  1  capture data_in as destination address this cycle
data_in  in  ADDR_W  destination address from header byte
write_enb_reg  in  1  FSM request to write current byte to the addressed FIFO
read_enb  in  NUM_CH  per-FIFO read enable from downstream
empty  in  NUM_CH  per-FIFO empty flags
full  in  NUM_CH  per-FIFO full flags
valid_out  out  NUM_CH  per-FIFO data-available (~empty)
write_enb  out  NUM_CH  one-hot (or zero) FIFO write enable
fifo_full  out  1  full flag of addressed FIFO
addr_err  out  1  latched address >= NUM_CH
soft_rst  out  NUM_CH  one-cycle FIFO flush pulse per channel

Behaviour:
- Reset: addr_reg=0, all timeout counters=0, all timer FSMs=IDLE, soft_rst=0. Combinational outputs follow from reset state: write_enb=0 unless write_enb_reg, addr_err=0, fifo_full=full[0].
- Address: addr_reg<=data_in on clk when detect_add; otherwise it holds its value.
- addr_valid = (addr_reg < NUM_CH); addr_err = ~addr_valid (combinational from addr_reg).
- write_enb[i] = write_enb_reg & addr_valid & (addr_reg==i). This is combinational and 0-latency. detect_add and write_enb_reg in the same cycle: write_enb uses the OLD addr_reg.
- fifo_full = addr_valid ? full[addr_reg] : 1'b1. An invalid address reports full so the FSM stalls rather than writing; the FSM uses addr_err to drop the packet.
- valid_out[i] = ~empty[i], combinational.
- Per-channel timer FSM, states IDLE/COUNT/FLUSH:
  - IDLE: cnt=0. Moves to COUNT when valid_out[i] & ~read_enb[i], loading cnt=1.
  - COUNT: read_enb[i] or empty[i] -> IDLE, cnt=0. Else if cnt==TIMEOUT-1 -> FLUSH. Else cnt++.
  - FLUSH: soft_rst[i]=1 for exactly this one cycle, cnt=0, unconditional -> IDLE.
  - soft_rst is registered (decoded from state FLUSH).
  - Latency: first unread-valid cycle at edge k gives soft_rst high during cycle k+TIMEOUT.
  - read_enb in the same cycle as the terminal count: the read wins, no flush.
  - Channels are fully independent; multiple channels may flush in the same cycle.
- Reset mid-count: all FSMs go to IDLE and cnt=0 on the next edge; a pending flush is discarded.
- No wrap-around on cnt: it never exceeds TIMEOUT-1.

Optional Feature:
ROUTER_SYNC_STATS_EN defined: adds output flush_count [NUM_CH*8-1:0], one 8-bit saturating counter per channel. Each counter increments on every FLUSH cycle, holds at 255, and is cleared by rst.
Undefined: the port and counters are absent; all other behaviour is identical.

Decomposition:
- Package router_pkg: ADDR_W/NUM_CH defaults, the timer state enum (IDLE=2'd0, COUNT=2'd1, FLUSH=2'd2), and the STATS counter width constant (8).
- One sub-module, router_sync_timer: a single-channel timer FSM (inputs clk, rst, valid, read_enb, empty; output soft_rst; parameter TIMEOUT). It is instantiated NUM_CH times in a generate loop.
- Address latch, write decode and full mux stay in the top module.

Test Plan:
1. rst=1 for 2 cycles, then NUM_CH=3, detect_add with data_in=2, then write_enb_reg=1 -> write_enb=3'b100; full=3'b100 -> fifo_full=1.
2. detect_add with data_in=3 (invalid), write_enb_reg=1 -> write_enb=0, addr_err=1, fifo_full=1; then detect_add with data_in=0 -> addr_err=0, write_enb=3'b001.
3. empty[1]=0 and read_enb[1]=0 held from edge k -> soft_rst[1]=1 only in cycle k+30, 0 at k+29 and k+31; the channel then re-arms and, if still unread, flushes again at k+61.
4. Same as 3, but read_enb[1]=1 in cycle k+29 -> no soft_rst, FSM returns to IDLE; also empty[1]=1 mid-count -> counter clears and no pulse occurs.
5. Channels 0 and 2 stalled from the same edge -> simultaneous soft_rst=3'b101; rst=1 asserted at cycle k+20 -> no pulse, counters 0.
6. With ROUTER_SYNC_STATS_EN defined, force 260 flushes on channel 0 -> flush_count[7:0] saturates at 255 and other channels read 0; rst clears it to 0.

Source files
------------

// File: rtl/router_pkg.sv
// Shared definitions for the router output synchronizer.
// Contents: default channel count and address width, the per-channel
// timeout FSM state encoding, and the width of the optional flush statistics
// counters (enabled with ROUTER_SYNC_STATS_EN).
package router_pkg;

    localparam int unsigned NUM_CH_DEF = 3;
    localparam int unsigned ADDR_W_DEF = 2;
    localparam int unsigned STATS_W    = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        FLUSH = 2'd2
    } timer_state_e;

endpackage : router_pkg

// File: rtl/router_sync_timer.sv
// Single-channel FIFO head timeout monitor.
// Counts consecutive cycles in which the FIFO holds data that is not read.
// After TIMEOUT such cycles it emits a one-cycle soft_rst pulse that flushes
// the FIFO, then re-arms.
// Ports:
//   clk      in   system clock
//   rst      in   synchronous active-high reset
//   valid    in   FIFO has data (~empty)
//   read_enb in   downstream reads the FIFO this cycle
//   empty    in   FIFO empty flag
//   soft_rst out  registered one-cycle flush pulse
module router_sync_timer
    import router_pkg::*;
#(
    parameter int unsigned TIMEOUT = 30
) (
    input  logic clk,
    input  logic rst,
    input  logic valid,
    input  logic read_enb,
    input  logic empty,
    output logic soft_rst
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT);

    timer_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // State, counter and pulse registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            soft_rst <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            soft_rst <= (state_d == FLUSH);
        end
    end

    // Next-state logic; a read or an emptied FIFO takes priority over the
    // terminal count so a head consumed on the last cycle is never flushed.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (valid && !read_enb) begin
                    state_d = COUNT;
                    cnt_d   = CNT_W'(1);
                end
            end
            COUNT: begin
                if (read_enb || empty) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d = FLUSH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            FLUSH: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

endmodule : router_sync_timer

// File: rtl/router_sync_n.sv
// N-channel synchronizer between the router FSM/register front end and the
// per-destination output FIFOs. Latches the destination address, steers the
// write enable to one FIFO, returns the addressed FIFO's full flag, drives
// valid_out and flushes any FIFO whose head stays unread for TIMEOUT cycles.
// Optional build macro: ROUTER_SYNC_STATS_EN adds per-channel 8-bit
// saturating flush counters on output flush_count.
// Ports:
//   clk           in   system clock
//   rst           in   synchronous active-high reset
//   detect_add    in   capture data_in as destination address
//   data_in       in   destination address [ADDR_W]
//   write_enb_reg in   FSM write request for the current byte
//   read_enb      in   per-FIFO read enables [NUM_CH]
//   empty         in   per-FIFO empty flags [NUM_CH]
//   full          in   per-FIFO full flags [NUM_CH]
//   valid_out     out  per-FIFO data available [NUM_CH]
//   write_enb     out  one-hot or zero FIFO write enable [NUM_CH]
//   fifo_full     out  full flag of addressed FIFO (1 for invalid address)
//   addr_err      out  latched address is not a valid channel
//   soft_rst      out  one-cycle FIFO flush pulses [NUM_CH]
//   flush_count   out  per-channel flush counters [NUM_CH*8] (stats build only)
module router_sync_n
    import router_pkg::*;
#(
    parameter int unsigned NUM_CH  = NUM_CH_DEF,
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned TIMEOUT = 30
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              detect_add,
    input  logic [ADDR_W-1:0] data_in,
    input  logic              write_enb_reg,
    input  logic [NUM_CH-1:0] read_enb,
    input  logic [NUM_CH-1:0] empty,
    input  logic [NUM_CH-1:0] full,
    output logic [NUM_CH-1:0] valid_out,
    output logic [NUM_CH-1:0] write_enb,
    output logic              fifo_full,
    output logic              addr_err,
    output logic [NUM_CH-1:0] soft_rst
`ifdef ROUTER_SYNC_STATS_EN
    ,
    output logic [NUM_CH*STATS_W-1:0] flush_count
`endif
);

    logic [ADDR_W-1:0] addr_reg;

    // Destination address latch
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_reg <= '0;
        end else if (detect_add) begin
            addr_reg <= data_in;
        end
    end

    assign addr_err  = !(32'(addr_reg) < NUM_CH);
    assign valid_out = ~empty;

    // Write decode and full mux; an out-of-range address matches no channel,
    // which leaves write_enb at zero and reports full so the FSM stalls.
    always_comb begin
        write_enb = '0;
        fifo_full = 1'b1;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (addr_reg == ADDR_W'(i)) begin
                write_enb[i] = write_enb_reg;
                fifo_full    = full[i];
            end
        end
    end

    // Independent timeout monitor per channel
    for (genvar g = 0; g < NUM_CH; g++) begin : g_timer
        router_sync_timer #(
            .TIMEOUT (TIMEOUT)
        ) u_timer (
            .clk      (clk),
            .rst      (rst),
            .valid    (valid_out[g]),
            .read_enb (read_enb[g]),
            .empty    (empty[g]),
            .soft_rst (soft_rst[g])
        );
    end

`ifdef ROUTER_SYNC_STATS_EN
    // Saturating count of flush pulses per channel
    for (genvar g = 0; g < NUM_CH; g++) begin : g_stats
        logic [STATS_W-1:0] fc_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                fc_q <= '0;
            end else if (soft_rst[g] && (fc_q != '1)) begin
                fc_q <= fc_q + STATS_W'(1);
            end
        end

        assign flush_count[g*STATS_W +: STATS_W] = fc_q;
    end
`else
    // Statistics build option disabled: no flush counters.
`endif

endmodule : router_sync_n

// File: tb/tb_router_sync_n.sv
// Self-checking bench for router_sync_n (NUM_CH=3, ADDR_W=2, TIMEOUT=30).
// Stimulus pushes expected combinational snapshots and expected flush pulses
// (edge index + channel mask) into queues; a negedge monitor compares them.
module tb_router_sync_n;

    localparam int unsigned NUM_CH  = 3;
    localparam int unsigned ADDR_W  = 2;
    localparam int unsigned TIMEOUT = 30;

    typedef struct {
        string       name;
        logic [2:0]  we;
        logic        ff;
        logic        ae;
        logic [2:0]  vo;
        logic [2:0]  sr;
        logic        do_fc;
        logic [23:0] fc;
    } comb_t;

    typedef struct {
        int         at;
        logic [2:0] mask;
    } pulse_t;

    logic              clk;
    logic              rst;
    logic              detect_add;
    logic [ADDR_W-1:0] data_in;
    logic              write_enb_reg;
    logic [NUM_CH-1:0] read_enb;
    logic [NUM_CH-1:0] empty;
    logic [NUM_CH-1:0] full;
    logic [NUM_CH-1:0] valid_out;
    logic [NUM_CH-1:0] write_enb;
    logic              fifo_full;
    logic              addr_err;
    logic [NUM_CH-1:0] soft_rst;
`ifdef ROUTER_SYNC_STATS_EN
    logic [NUM_CH*8-1:0] flush_count;
`endif

    comb_t  exp_q[$];
    pulse_t pulse_q[$];
    logic   chk_req;
    logic   end_req;
    int     ecnt;
    int     checks;
    int     errors;

    router_sync_n #(
        .NUM_CH  (NUM_CH),
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .detect_add    (detect_add),
        .data_in       (data_in),
        .write_enb_reg (write_enb_reg),
        .read_enb      (read_enb),
        .empty         (empty),
        .full          (full),
        .valid_out     (valid_out),
        .write_enb     (write_enb),
        .fifo_full     (fifo_full),
        .addr_err      (addr_err),
        .soft_rst      (soft_rst)
`ifdef ROUTER_SYNC_STATS_EN
        ,
        .flush_count   (flush_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial ecnt = 0;
    always @(posedge clk) ecnt <= ecnt + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Queue an expected snapshot, let the monitor see it, advance one edge
    task automatic chk(input string name, input logic [2:0] we, input logic ff,
                       input logic ae, input logic [2:0] vo,
                       input logic do_fc = 1'b0, input logic [23:0] fc = '0);
        comb_t e;
        e.name  = name;
        e.we    = we;
        e.ff    = ff;
        e.ae    = ae;
        e.vo    = vo;
        e.sr    = 3'b000;
        e.do_fc = do_fc;
        e.fc    = fc;
        exp_q.push_back(e);
        chk_req = 1'b1;
        tick();
        chk_req = 1'b0;
    endtask

    task automatic exp_pulse(input int at, input logic [2:0] mask);
        pulse_t p;
        p.at   = at;
        p.mask = mask;
        pulse_q.push_back(p);
    endtask

    // Monitor: compares snapshots and every flush pulse against the queues
    always @(negedge clk) begin
        comb_t  e;
        pulse_t p;
        if (chk_req) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL comb_queue_empty: snapshot requested with no expectation");
            end else begin
                e = exp_q.pop_front();
                if (write_enb !== e.we || fifo_full !== e.ff || addr_err !== e.ae ||
                    valid_out !== e.vo || soft_rst !== e.sr) begin
                    errors++;
                    $display("FAIL %s: got we=%b ff=%b ae=%b vo=%b sr=%b, expected we=%b ff=%b ae=%b vo=%b sr=%b",
                             e.name, write_enb, fifo_full, addr_err, valid_out, soft_rst,
                             e.we, e.ff, e.ae, e.vo, e.sr);
                end
`ifdef ROUTER_SYNC_STATS_EN
                if (e.do_fc) begin
                    checks++;
                    if (flush_count !== e.fc) begin
                        errors++;
                        $display("FAIL %s_flush_count: got %h, expected %h", e.name, flush_count, e.fc);
                    end
                end
`endif
            end
        end
        if (soft_rst !== 3'b000) begin
            checks++;
            if (pulse_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_soft_rst: got %b at edge %0d, expected none", soft_rst, ecnt);
            end else begin
                p = pulse_q.pop_front();
                if (soft_rst !== p.mask || ecnt != p.at) begin
                    errors++;
                    $display("FAIL soft_rst_pulse: got %b at edge %0d, expected %b at edge %0d",
                             soft_rst, ecnt, p.mask, p.at);
                end
            end
        end
        if (end_req) begin
            checks++;
            if (pulse_q.size() != 0) begin
                errors++;
                $display("FAIL missing_soft_rst: %0d pulses outstanding, next expected %b at edge %0d, expected 0 outstanding",
                         pulse_q.size(), pulse_q[0].mask, pulse_q[0].at);
            end
            checks++;
            if (exp_q.size() != 0) begin
                errors++;
                $display("FAIL comb_unchecked: %0d snapshots outstanding, expected 0", exp_q.size());
            end
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
        end
    end

    initial begin
        int e0;
        checks        = 0;
        errors        = 0;
        chk_req       = 1'b0;
        end_req       = 1'b0;
        rst           = 1'b1;
        detect_add    = 1'b0;
        data_in       = '0;
        write_enb_reg = 1'b0;
        read_enb      = 3'b000;
        empty         = 3'b111;
        full          = 3'b001;
        tick();
        tick();

        // Reset state: address 0, fifo_full follows full[0]
        chk("reset_state", 3'b000, 1'b1, 1'b0, 3'b000);
        rst           = 1'b0;
        write_enb_reg = 1'b1;
        chk("reset_addr0_write", 3'b001, 1'b1, 1'b0, 3'b000);

        // Latch address 2 and write
        write_enb_reg = 1'b0;
        detect_add    = 1'b1;
        data_in       = 2'd2;
        chk("latch2_pending", 3'b000, 1'b1, 1'b0, 3'b000);
        detect_add    = 1'b0;
        write_enb_reg = 1'b1;
        full          = 3'b100;
        chk("addr2_write_full", 3'b100, 1'b1, 1'b0, 3'b000);
        full          = 3'b011;
        chk("addr2_write_notfull", 3'b100, 1'b0, 1'b0, 3'b000);

        // Same-cycle detect uses the old address; then invalid address 3
        detect_add    = 1'b1;
        data_in       = 2'd3;
        chk("detect_same_cycle_old_addr", 3'b100, 1'b0, 1'b0, 3'b000);
        detect_add    = 1'b0;
        full          = 3'b000;
        chk("addr3_invalid", 3'b000, 1'b1, 1'b1, 3'b000);
        detect_add    = 1'b1;
        data_in       = 2'd0;
        chk("latch0_pending", 3'b000, 1'b1, 1'b1, 3'b000);
        detect_add    = 1'b0;
        full          = 3'b001;
        chk("addr0_write_full", 3'b001, 1'b1, 1'b0, 3'b000);
        full          = 3'b110;
        chk("addr0_write_notfull", 3'b001, 1'b0, 1'b0, 3'b000);

        // valid_out mirrors ~empty (reads held so no timer starts)
        write_enb_reg = 1'b0;
        empty         = 3'b110;
        read_enb      = 3'b001;
        chk("valid_out_ch0", 3'b000, 1'b0, 1'b0, 3'b001);
        empty         = 3'b011;
        read_enb      = 3'b100;
        chk("valid_out_ch2", 3'b000, 1'b0, 1'b0, 3'b100);
        empty         = 3'b111;
        read_enb      = 3'b000;
        full          = 3'b000;
        tick();

        // Channel 1 stalled: flush at +30, re-arm, flush again at +61
        e0    = ecnt;
        empty = 3'b101;
        exp_pulse(e0 + 30, 3'b010);
        exp_pulse(e0 + 61, 3'b010);
        repeat (62) tick();
        empty = 3'b111;
        repeat (3) tick();

        // Read on the terminal-count cycle wins: no flush
        e0    = ecnt;
        empty = 3'b101;
        repeat (29) tick();
        read_enb = 3'b010;
        tick();
        read_enb = 3'b000;
        empty    = 3'b111;
        repeat (35) tick();

        // Empty mid-count clears the counter; flush follows from the restart
        empty = 3'b101;
        repeat (15) tick();
        empty = 3'b111;
        tick();
        e0    = ecnt;
        empty = 3'b101;
        exp_pulse(e0 + 30, 3'b010);
        repeat (31) tick();
        empty = 3'b111;
        repeat (3) tick();

        // Channels 0 and 2 flush together
        e0    = ecnt;
        empty = 3'b010;
        exp_pulse(e0 + 30, 3'b101);
        repeat (31) tick();
        empty = 3'b111;
        repeat (3) tick();

        // Reset at +20 discards the count; flush only 30 edges after release
        empty = 3'b010;
        repeat (20) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        e0  = ecnt;
        exp_pulse(e0 + 30, 3'b101);
        repeat (31) tick();
        empty = 3'b111;
        repeat (3) tick();

`ifdef ROUTER_SYNC_STATS_EN
        // 260 flushes on channel 0 saturate its counter at 255
        e0    = ecnt;
        empty = 3'b110;
        for (int j = 0; j < 260; j++) exp_pulse(e0 + 30 + 31 * j, 3'b001);
        repeat (30 + 31 * 259 + 1) tick();
        empty = 3'b111;
        repeat (2) tick();
        chk("stats_saturate", 3'b000, 1'b0, 1'b0, 3'b000, 1'b1, 24'h0000FF);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("stats_cleared", 3'b000, 1'b0, 1'b0, 3'b000, 1'b1, 24'h000000);
`endif

        end_req = 1'b1;
        repeat (5) tick();
        $display("FAIL end_not_reached: monitor did not finish, expected summary");
        $fatal(1);
    end

endmodule : tb_router_sync_n
